// File: rtl/ram_fifo_arb_pkg.sv
// Shared types for the two-requester RAM FIFO: requester identifiers and the
// round-robin pick used by the write arbiter.
package ram_fifo_arb_pkg;

   typedef enum logic {
      REQ0 = 1'b0,
      REQ1 = 1'b1
   } req_e;

   // A lone requester wins; on a tie (or no request) the one not granted last is picked.
   function automatic req_e arb_pick(input logic v0, input logic v1, input req_e last);
      req_e g;
      case ({v0, v1})
         2'b10:   g = REQ0;
         2'b01:   g = REQ1;
         2'b11:   g = (last == REQ0) ? REQ1 : REQ0;
         default: g = (last == REQ0) ? REQ1 : REQ0;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/ram_fifo_arb_ram.sv
// Simple dual-port block RAM: one synchronous write port, one registered read port.
// Contents are never reset.
module simple_dual_ram_64 #(
   parameter int SIZE  = 8,
   parameter int DEPTH = 64
) (
   input  logic                     wclk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [SIZE-1:0]          wdata,
   input  logic                     rclk,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [SIZE-1:0]          rdata
);

   logic [SIZE-1:0] r_mem [DEPTH];

   // write port
   always_ff @(posedge wclk) begin
      if (we) begin
         r_mem[waddr] <= wdata;
      end
   end

   // registered read port
   always_ff @(posedge rclk) begin
      rdata <= r_mem[raddr];
   end

endmodule

// File: rtl/ram_fifo_arb.sv
// Two-requester round-robin FIFO sharing one dual-port RAM, drained in arrival
// order through a first-word-fall-through output.
module ram_fifo_arb
   import ram_fifo_arb_pkg::*;
#(
   parameter int SIZE  = 8,
   parameter int DEPTH = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [SIZE-1:0]          in0_data,
   input  logic                     in0_valid,
   output logic                     in0_ready,
   input  logic [SIZE-1:0]          in1_data,
   input  logic                     in1_valid,
   output logic                     in1_ready,
   output logic [SIZE-1:0]          out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int                AW       = $clog2(DEPTH);
   localparam int                PTR_W    = AW + 1;
   localparam logic [PTR_W-1:0] FULL_CNT = PTR_W'(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};

   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   req_e             r_last;
   logic             r_out_valid;

   req_e             w_grant;
   logic [PTR_W-1:0] w_count;
   logic [PTR_W-1:0] w_rptr_next;
   logic             w_full;
   logic             w_push;
   logic             w_pop;
   logic [SIZE-1:0]  w_wdata;
   logic [SIZE-1:0]  w_rdata;

   // arbitration, handshakes and status derived from the registered pointers
   always_comb begin
      w_grant     = arb_pick(in0_valid, in1_valid, r_last);
      w_count     = r_wptr - r_rptr;
      w_full      = (w_count == FULL_CNT);
      in0_ready   = !w_full && (w_grant == REQ0);
      in1_ready   = !w_full && (w_grant == REQ1);
      w_push      = (in0_valid && in0_ready) || (in1_valid && in1_ready);
      w_wdata     = (w_grant == REQ0) ? in0_data : in1_data;
      w_pop       = r_out_valid && out_ready;
      w_rptr_next = w_pop ? (r_rptr + PTR_ONE) : r_rptr;
      count       = w_count;
      full        = w_full;
      empty       = (w_count == {PTR_W{1'b0}});
      out_valid   = r_out_valid;
      out_data    = w_rdata;
   end

   // pointers, arbitration history and head-valid flag
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr      <= {PTR_W{1'b0}};
         r_rptr      <= {PTR_W{1'b0}};
         r_last      <= REQ1;
         r_out_valid <= 1'b0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + PTR_ONE;
            r_last <= w_grant;
         end
         r_rptr <= w_rptr_next;
         // pre-edge wptr keeps a word written this edge hidden until the RAM has it
         r_out_valid <= (r_wptr != w_rptr_next);
      end
   end

   simple_dual_ram_64 #(
      .SIZE  (SIZE),
      .DEPTH (DEPTH)
   ) u_ram (
      .wclk  (clk),
      .we    (w_push),
      .waddr (r_wptr[AW-1:0]),
      .wdata (w_wdata),
      .rclk  (clk),
      .raddr (w_rptr_next[AW-1:0]),
      .rdata (w_rdata)
   );

endmodule

// File: tb/tb_ram_fifo_arb.sv
// Self-checking bench for ram_fifo_arb: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_ram_fifo_arb;

   localparam int SIZE  = 8;
   localparam int DEPTH = 8;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [7:0]    in0_data = 8'h00, in1_data = 8'h00, out_data;
   logic          in0_valid = 1'b0, in1_valid = 1'b0, out_ready = 1'b0;
   logic          in0_ready, in1_ready, out_valid, full, empty;
   logic [CW-1:0] count;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] mq[$];
   bit         m_last = 1'b1;
   bit         m_ov   = 1'b0;
   logic [7:0] obs_pop[$];

   ram_fifo_arb #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .in0_data(in0_data), .in0_valid(in0_valid), .in0_ready(in0_ready),
      .in1_data(in1_data), .in1_valid(in1_valid), .in1_ready(in1_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .count(count), .full(full), .empty(empty)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete within time limit");
      $fatal(1, "timeout");
   end

   function automatic int m_grant();
      if (in0_valid && !in1_valid) return 0;
      if (in1_valid && !in0_valid) return 1;
      return m_last ? 0 : 1;
   endfunction

   task automatic drive(input bit v0, input logic [7:0] d0, input bit v1,
                        input logic [7:0] d1, input bit ordy);
      in0_valid = v0; in0_data = d0; in1_valid = v1; in1_data = d1; out_ready = ordy;
      #1;
   endtask

   // Advance the reference model by the handshake rules, then clock the DUT.
   task automatic tick();
      int g;
      bit push, pop;
      int pre;
      g    = m_grant();
      push = (mq.size() < DEPTH) && ((g == 0 && in0_valid) || (g == 1 && in1_valid));
      pop  = m_ov && out_ready;
      if (rst) begin
         mq.delete(); m_last = 1'b1; m_ov = 1'b0;
      end else begin
         pre = mq.size();
         if (pop) void'(mq.pop_front());
         m_ov = (pre - int'(pop)) > 0;
         if (push) begin
            mq.push_back(g == 0 ? in0_data : in1_data);
            m_last = (g == 1);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0); tick(); rst = 1'b0;
      obs_pop.delete();
   endtask

   task automatic drain(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
         if (out_valid) obs_pop.push_back(out_data);
         tick();
      end
   endtask

   task automatic test_reset();
      do_reset();
      drive(1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
      n_checks++; if (count !== CW'(0)) begin n_errors++; $display("FAIL reset_count: got %0d expected 0", count); end
      n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
      n_checks++; if (full !== 1'b0) begin n_errors++; $display("FAIL reset_full: got %b expected 0", full); end
      n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      n_checks++; if (in0_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in0_ready: got %b expected 1", in0_ready); end
      drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic test_single_stream();
      logic [7:0] words [3];
      bit exp_ov;
      words = '{8'h11, 8'h22, 8'h33};
      do_reset();
      for (int c = 0; c < 6; c++) begin
         drive(c < 3, (c < 3) ? words[c] : 8'h00, 1'b0, 8'h00, 1'b1);
         exp_ov = (c >= 2) && (c <= 4);
         if (c < 3) begin
            n_checks++; if (in0_ready !== 1'b1) begin n_errors++; $display("FAIL single_ready c=%0d: got %b expected 1", c, in0_ready); end
         end
         n_checks++; if (out_valid !== exp_ov) begin n_errors++; $display("FAIL single_out_valid c=%0d: got %b expected %b", c, out_valid, exp_ov); end
         n_checks++; if (count !== CW'(mq.size())) begin n_errors++; $display("FAIL single_count c=%0d: got %0d expected %0d", c, count, mq.size()); end
         if (out_valid && out_ready) obs_pop.push_back(out_data);
         tick();
      end
      n_checks++; if (obs_pop.size() != 3) begin n_errors++; $display("FAIL single_npop: got %0d expected 3", obs_pop.size()); end
      for (int k = 0; k < 3 && k < obs_pop.size(); k++) begin
         n_checks++; if (obs_pop[k] !== words[k]) begin n_errors++; $display("FAIL single_data k=%0d: got %h expected %h", k, obs_pop[k], words[k]); end
      end
   endtask

   task automatic test_tie_arbitration();
      logic [7:0] acc[$];
      logic [7:0] exp_w;
      int n0 = 0, n1 = 0;
      do_reset();
      for (int c = 0; c < 10; c++) begin
         drive(1'b1, 8'(8'hA0 + n0), 1'b1, 8'(8'hB0 + n1), 1'b1);
         if (c == 0) begin
            n_checks++; if (in0_ready !== 1'b1 || in1_ready !== 1'b0) begin n_errors++; $display("FAIL tie_first: got r0=%b r1=%b expected r0=1 r1=0", in0_ready, in1_ready); end
         end
         n_checks++; if (in0_ready && in1_ready) begin n_errors++; $display("FAIL tie_double_grant c=%0d: got both ready expected one", c); end
         if (in0_ready) begin acc.push_back(in0_data); n0++; end
         else if (in1_ready) begin acc.push_back(in1_data); n1++; end
         if (out_valid) obs_pop.push_back(out_data);
         tick();
      end
      drain(6);
      n_checks++; if (acc.size() != 10 || obs_pop.size() != 10) begin n_errors++; $display("FAIL tie_counts: got acc=%0d pop=%0d expected 10 10", acc.size(), obs_pop.size()); end
      for (int k = 0; k < 10 && k < acc.size() && k < obs_pop.size(); k++) begin
         exp_w = (k % 2 == 0) ? 8'(8'hA0 + k / 2) : 8'(8'hB0 + k / 2);
         n_checks++; if (acc[k] !== exp_w) begin n_errors++; $display("FAIL tie_grant k=%0d: got %h expected %h", k, acc[k], exp_w); end
         n_checks++; if (obs_pop[k] !== exp_w) begin n_errors++; $display("FAIL tie_out k=%0d: got %h expected %h", k, obs_pop[k], exp_w); end
      end
   endtask

   task automatic test_fill_wrap();
      logic [7:0] exp_w;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 8'h00, 1'b1, 8'(8'hC0 + i), 1'b0);
         n_checks++; if (in1_ready !== 1'b1) begin n_errors++; $display("FAIL fill_ready i=%0d: got %b expected 1", i, in1_ready); end
         tick();
      end
      drive(1'b1, 8'hD0, 1'b1, 8'hD1, 1'b0);
      n_checks++; if (full !== 1'b1 || count !== CW'(8)) begin n_errors++; $display("FAIL fill_full: got full=%b count=%0d expected 1 8", full, count); end
      n_checks++; if (in0_ready !== 1'b0 || in1_ready !== 1'b0) begin n_errors++; $display("FAIL fill_readys: got %b%b expected 00", in0_ready, in1_ready); end
      // full boundary: a pop while full does not open ready in the same cycle
      drive(1'b1, 8'hD0, 1'b0, 8'h00, 1'b1);
      n_checks++; if (in0_ready !== 1'b0) begin n_errors++; $display("FAIL boundary_same: got %b expected 0", in0_ready); end
      if (out_valid) obs_pop.push_back(out_data);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 8'(8'hD0 + i), 1'b0, 8'h00, 1'b1);
         if (i == 0) begin
            n_checks++; if (in0_ready !== 1'b1 || count !== CW'(7)) begin n_errors++; $display("FAIL boundary_next: got ready=%b count=%0d expected 1 7", in0_ready, count); end
         end
         if (out_valid) obs_pop.push_back(out_data);
         tick();
      end
      drain(12);
      n_checks++; if (obs_pop.size() != 11) begin n_errors++; $display("FAIL wrap_npop: got %0d expected 11", obs_pop.size()); end
      for (int k = 0; k < 11 && k < obs_pop.size(); k++) begin
         exp_w = (k < 8) ? 8'(8'hC0 + k) : 8'(8'hD0 + k - 8);
         n_checks++; if (obs_pop[k] !== exp_w) begin n_errors++; $display("FAIL wrap_data k=%0d: got %h expected %h", k, obs_pop[k], exp_w); end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_w;
      do_reset();
      for (int i = 0; i < 4; i++) begin drive(1'b1, 8'(8'hE0 + i), 1'b0, 8'h00, 1'b0); tick(); end
      drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0); tick();
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 8'(8'hF0 + i), 1'b0, 8'h00, 1'b1);
         n_checks++; if (count !== CW'(4) || in0_ready !== 1'b1 || out_valid !== 1'b1) begin n_errors++; $display("FAIL simul_state i=%0d: got count=%0d ready=%b ov=%b expected 4 1 1", i, count, in0_ready, out_valid); end
         if (out_valid) obs_pop.push_back(out_data);
         tick();
      end
      drain(8);
      n_checks++; if (obs_pop.size() != 10) begin n_errors++; $display("FAIL simul_npop: got %0d expected 10", obs_pop.size()); end
      for (int k = 0; k < 10 && k < obs_pop.size(); k++) begin
         exp_w = (k < 4) ? 8'(8'hE0 + k) : 8'(8'hF0 + k - 4);
         n_checks++; if (obs_pop[k] !== exp_w) begin n_errors++; $display("FAIL simul_data k=%0d: got %h expected %h", k, obs_pop[k], exp_w); end
      end
   endtask

   task automatic test_reset_mid();
      bit seen = 1'b0;
      do_reset();
      for (int i = 0; i < 5; i++) begin drive(1'b0, 8'h00, 1'b1, 8'(8'h90 + i), 1'b0); tick(); end
      drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0); tick();
      n_checks++; if (count !== CW'(5)) begin n_errors++; $display("FAIL mid_precount: got %0d expected 5", count); end
      rst = 1'b1; tick(); rst = 1'b0;
      n_checks++; if (count !== CW'(0) || empty !== 1'b1 || out_valid !== 1'b0) begin n_errors++; $display("FAIL mid_cleared: got count=%0d empty=%b ov=%b expected 0 1 0", count, empty, out_valid); end
      drive(1'b1, 8'h5A, 1'b0, 8'h00, 1'b1); tick();
      for (int i = 0; i < 5 && !seen; i++) begin
         drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
         if (out_valid) begin
            seen = 1'b1;
            n_checks++; if (out_data !== 8'h5A) begin n_errors++; $display("FAIL mid_first_word: got %h expected 5a", out_data); end
         end
         tick();
      end
      n_checks++; if (!seen) begin n_errors++; $display("FAIL mid_timeout: got no out_valid expected 5a within 5 cycles"); end
   endtask

   task automatic test_random();
      int thr;
      bit e0, e1, ef;
      do_reset();
      for (int c = 0; c < 800; c++) begin
         thr = ((c / 100) % 2 == 0) ? 30 : 85;
         drive($urandom_range(0, 99) < 60, 8'($urandom), $urandom_range(0, 99) < 60, 8'($urandom),
               $urandom_range(0, 99) < thr);
         ef = (mq.size() == DEPTH);
         e0 = !ef && (m_grant() == 0);
         e1 = !ef && (m_grant() == 1);
         n_checks++; if (count !== CW'(mq.size())) begin n_errors++; $display("FAIL rnd_count c=%0d: got %0d expected %0d", c, count, mq.size()); end
         n_checks++; if (full !== ef || empty !== (mq.size() == 0)) begin n_errors++; $display("FAIL rnd_flags c=%0d: got full=%b empty=%b expected %b %b", c, full, empty, ef, mq.size() == 0); end
         n_checks++; if (out_valid !== m_ov) begin n_errors++; $display("FAIL rnd_out_valid c=%0d: got %b expected %b", c, out_valid, m_ov); end
         if (m_ov) begin
            n_checks++; if (out_data !== mq[0]) begin n_errors++; $display("FAIL rnd_out_data c=%0d: got %h expected %h", c, out_data, mq[0]); end
         end
         if (in0_valid) begin
            n_checks++; if (in0_ready !== e0) begin n_errors++; $display("FAIL rnd_in0_ready c=%0d: got %b expected %b", c, in0_ready, e0); end
         end
         if (in1_valid) begin
            n_checks++; if (in1_ready !== e1) begin n_errors++; $display("FAIL rnd_in1_ready c=%0d: got %b expected %b", c, in1_ready, e1); end
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_single_stream();
      test_tie_arbitration();
      test_fill_wrap();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
